// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding a downstream sync FIFO.
// rx_in is resynchronised, frames are sampled mid-bit, and each good byte
// is presented on data_out with a single-cycle wr_en strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_in,
    input  logic             fifo_full,
    output logic [WIDTH-1:0] data_out,
    output logic             wr_en,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_clk_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_armed;   // line has been seen high while idle
    logic               w_rx_s;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser; resets high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM: start qualification, mid-bit sampling, stop-bit decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            data_out    <= '0;
            wr_en       <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s && r_armed) begin
                        r_state   <= START;
                        r_clk_cnt <= '0;
                        r_armed   <= 1'b0;
                        busy      <= 1'b1;
                    end else if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end
                end
                START: begin
                    if (r_clk_cnt == HALF_M1) begin
                        r_clk_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise
                            r_state <= IDLE;
                            r_armed <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == LAST_BIT)
                            r_state <= STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            // Leave at mid stop bit so a following start edge is caught
                            r_state <= IDLE;
                            r_armed <= 1'b1;
                            busy    <= 1'b0;
                            if (fifo_full) begin
                                overrun_err <= 1'b1;
                            end else begin
                                data_out <= r_shift;
                                wr_en    <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= BRK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                BRK: begin
                    // Line held low (break): wait for idle before hunting for a start
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_armed <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
